// File: rtl/coa_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder controller.
package coa_pkg;

  localparam int unsigned COA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } coa_state_t;

  // Bit-counter width able to hold 0..width-1 (at least one bit).
  function automatic int unsigned coa_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the sub port and two's-complement subtraction.
module serial_adder_ctrl
  import coa_pkg::*;
#(
  parameter int unsigned WIDTH = COA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = coa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  coa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_b, fa_s, fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
  // Subtraction feeds inverted B bits; the +1 comes from the preset carry.
  assign fa_b = b_q[0] ^ sub_q;
`else
  assign fa_b = b_q[0];
`endif

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Next-state, datapath and registered-flag logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
          carry_d = sub;
`else
          carry_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy_d  = 1'b1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Carry into the MSB is carry_q; carry out is the cell's cout.
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = res_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int unsigned  ai = a;
    int unsigned  bi = b;
    int unsigned  full;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (!s) begin
      full = ai + bi;
      r    = W'(full);
      c    = (full >= (32'd1 << W));
      v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r    = W'(ai - bi);
      c    = (ai >= bi);
      v    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, c, r};
  endfunction

  // One operation; disturb pulses start mid-SHIFT and in DONE with other operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit disturb, output logic [W+1:0] e);
    int lat;
    bit got_done;
    e = model(a, b, s);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
    lat = 0;
    got_done = 1'b0;
    while (!got_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got_done = 1'b1;
      end else if (disturb && lat == 3) begin
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
      end else begin
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
      end
    end
    check("done_latency", 32'(lat), 32'(W));
    check("sum", 32'(sum), 32'(e[W-1:0]));
    check("cout", 32'(cout), 32'(e[W]));
    check("ovf", 32'(ovf), 32'(e[W+1]));
    check("busy_in_done", 32'(busy), 32'd1);
    if (disturb) begin
      start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("sum_hold", 32'(sum), 32'(e[W-1:0]));
    check("cout_hold", 32'(cout), 32'(e[W]));
    @(posedge clk); #1;
    check("idle_busy2", 32'(busy), 32'd0);
    check("idle_done2", 32'(done), 32'd0);
  endtask

  logic [W+1:0] e;
  logic [W-1:0] ra, rb;
  logic         rs;
  bit           prev_busy;
  int           last, n_acc, seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, e);
    check("add_0f_01", 32'(sum), 32'h10);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, e);
    check("add_ff_01_cout", 32'({cout, sum}), 32'h100);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, e);
    check("add_7f_01_ovf", 32'({ovf, cout, sum}), 32'h280);
    run_op(8'h01, 8'h01, 1'b0, 1'b1, e);
    check("ignore_start", 32'(sum), 32'h02);

    // Reset on the 4th SHIFT edge aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op_a = 8'h01; op_b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_outs", 32'({ovf, cout, sum}), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("abort_quiet", 32'(seen_done), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, e);
    check("after_abort", 32'(sum), 32'h07);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op_a = 8'h11; op_b = 8'h22;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_sum", 32'(sum), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b0, e);
    check("sub_05_07", 32'({cout, sum}), 32'h0FE);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, e);
    check("sub_07_05", 32'({cout, sum}), 32'h102);
`endif

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, bit'($urandom_range(0, 1)), e);
    end

    // start held high: one acceptance every WIDTH+2 cycles.
    ra = W'($urandom);
    rb = W'($urandom);
    e  = model(ra, rb, 1'b0);
    @(negedge clk);
    start = 1'b1; op_a = ra; op_b = rb; sub = 1'b0;
    prev_busy = 1'b0;
    last = 0;
    n_acc = 0;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        if (n_acc > 0) check("b2b_gap", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        n_acc++;
      end
      if (done) check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
      prev_busy = busy;
    end
    check("b2b_count", 32'(n_acc), 32'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
